multicycle_control_fsm: RTL and testbench

Multi-cycle control unit for the team's RV32I-subset core. It sequences the shared datapath: PC/IR registers, register file, immediate generator, ALU and single unified memory port. It decodes Instr[6:0] for the same opcode set the immediate generator supports, plus R-type. It drives every datapath strobe and mux select, one state per cycle, and waits on a memory ready handshake.

---
 rtl/multicycle_control_fsm.sv | 238 +++++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control unit for the RV32I-subset core.
// The state register and the memory-wait watchdog are registered. The datapath
// strobes and mux selects are combinational from the state (Moore). MemReady
// and BranchTaken gate some of them where the datapath needs that.
// Optional build macro: ILLEGAL_TRAP_EN. When it is defined, unknown opcodes
// go to a TRAP state, and an extra output port Illegal is added.
module multicycle_control_fsm #(
    parameter int unsigned MEM_WAIT_MAX = 0     // 0 disables the memory-wait watchdog
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Instr,
    input  logic        BranchTaken,
    input  logic        MemReady,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        MemReq,
    output logic        MemWe,
    output logic        IorD,
    output logic        RegWrite,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic [1:0]  PCSrc,
    output logic [1:0]  WbSel,
    output logic [3:0]  State,
    output logic        Timeout
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic        Illegal
`endif
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        EXEC_ADDR = 4'd2,
        MEM_RD    = 4'd3,
        MEM_WR    = 4'd4,
        WB_MEM    = 4'd5,
        EXEC_ALU  = 4'd6,
        WB_ALU    = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9
`ifdef ILLEGAL_TRAP_EN
        ,
        TRAP      = 4'd10
`endif
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // The counter needs to hold values from 0 up to MEM_WAIT_MAX-1.
    // It is at least 1 bit wide, even when the watchdog is disabled.
    localparam int unsigned   CW        = $clog2(MEM_WAIT_MAX + 2);
    localparam logic [CW-1:0] WAIT_LAST = (MEM_WAIT_MAX > 0) ? CW'(MEM_WAIT_MAX - 1) : '0;
    localparam logic          WD_EN     = (MEM_WAIT_MAX > 0);

    state_t          state_reg;
    state_t          state_next;
    logic [CW-1:0]   wait_cnt_reg;
    logic [CW-1:0]   wait_cnt_next;
    logic [6:0]      opcode;
    logic            mem_wait_state;
    logic            wd_fire;
    logic            unused_instr_bits;

    assign opcode            = Instr[6:0];
    assign unused_instr_bits = ^Instr[31:7];
    assign State             = state_reg;

    assign mem_wait_state = (state_reg == FETCH) || (state_reg == MEM_RD) || (state_reg == MEM_WR);

    // The watchdog fires in the cycle where this wait cycle would bring the count up to MEM_WAIT_MAX.
    assign wd_fire = WD_EN && mem_wait_state && !MemReady && (wait_cnt_reg == WAIT_LAST);

    // Count consecutive stalled memory cycles. Any other cycle clears the count.
    always_comb begin
        wait_cnt_next = '0;
        if (WD_EN && mem_wait_state && !MemReady && !wd_fire) begin
            wait_cnt_next = wait_cnt_reg + CW'(1);
        end
    end

    // Next-state sequencing: decode the opcode, wait for the memory, and abort on the watchdog.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FETCH: begin
                if (wd_fire) begin
                    state_next = FETCH;
                end else if (MemReady) begin
                    state_next = DECODE;
                end
            end
            DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = EXEC_ADDR;
                    OP_OP, OP_IMM:     state_next = EXEC_ALU;
                    OP_BRANCH:         state_next = BRANCH;
                    OP_JAL, OP_JALR:   state_next = JUMP;
`ifdef ILLEGAL_TRAP_EN
                    default:           state_next = TRAP;
`else
                    default:           state_next = FETCH;
`endif
                endcase
            end
            EXEC_ADDR: state_next = (opcode == OP_STORE) ? MEM_WR : MEM_RD;
            MEM_RD: begin
                if (wd_fire) begin
                    state_next = FETCH;
                end else if (MemReady) begin
                    state_next = WB_MEM;
                end
            end
            MEM_WR: begin
                if (wd_fire || MemReady) begin
                    state_next = FETCH;
                end
            end
            WB_MEM:   state_next = FETCH;
            EXEC_ALU: state_next = WB_ALU;
            WB_ALU:   state_next = FETCH;
            BRANCH:   state_next = FETCH;
            JUMP:     state_next = FETCH;
`ifdef ILLEGAL_TRAP_EN
            TRAP:     state_next = TRAP;
`endif
            default:  state_next = FETCH;
        endcase
    end

    // State register and watchdog counter. Reset returns to FETCH with the counter cleared.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg    <= FETCH;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // Datapath strobes and selects for the current state. All of them are held at 0 while Reset is high.
    always_comb begin
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        MemReq   = 1'b0;
        MemWe    = 1'b0;
        IorD     = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA  = 2'b00;
        ALUSrcB  = 2'b00;
        ALUOp    = 2'b00;
        PCSrc    = 2'b00;
        WbSel    = 2'b00;
        Timeout  = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        Illegal  = 1'b0;
`endif
        if (!Reset) begin
            Timeout = wd_fire;
            case (state_reg)
                FETCH: begin
                    // PC+4 is computed on the ALU while the instruction word is being read.
                    MemReq  = !wd_fire;
                    ALUSrcB = 2'b01;
                    IRWrite = MemReady;
                    PCWrite = MemReady;
                end
                DECODE: begin
                    // Speculative branch/jump target: ALUOut <= OldPC + imm
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b10;
                end
                EXEC_ADDR: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b10;
                end
                MEM_RD: begin
                    MemReq = !wd_fire;
                    IorD   = 1'b1;
                end
                MEM_WR: begin
                    MemReq = !wd_fire;
                    MemWe  = !wd_fire;
                    IorD   = 1'b1;
                end
                WB_MEM: begin
                    RegWrite = 1'b1;
                    WbSel    = 2'b01;
                end
                EXEC_ALU: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = (opcode == OP_OP) ? 2'b00 : 2'b10;
                    ALUOp   = 2'b10;
                end
                WB_ALU: begin
                    RegWrite = 1'b1;
                end
                BRANCH: begin
                    ALUSrcA = 2'b10;
                    ALUOp   = 2'b01;
                    PCSrc   = 2'b01;
                    PCWrite = BranchTaken;
                end
                JUMP: begin
                    // rd <= PC, which already holds the return address (+4)
                    RegWrite = 1'b1;
                    WbSel    = 2'b10;
                    PCWrite  = 1'b1;
                    if (opcode == OP_JALR) begin
                        ALUSrcA = 2'b10;
                        ALUSrcB = 2'b10;
                        PCSrc   = 2'b10;
                    end else begin
                        PCSrc   = 2'b01;
                    end
                end
`ifdef ILLEGAL_TRAP_EN
                TRAP: begin
                    Illegal = 1'b1;
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed testbench for multicycle_control_fsm.
// u_dut is the default build, with the watchdog disabled.
// u_wd uses MEM_WAIT_MAX=4 and is held in reset until the watchdog sequence runs.
module tb_multicycle_control_fsm;

    logic        Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        Reset;
    logic [31:0] Instr;
    logic        BranchTaken;
    logic        MemReady;
    logic        PCWrite, IRWrite, MemReq, MemWe, IorD, RegWrite, Timeout;
    logic [1:0]  ALUSrcA, ALUSrcB, ALUOp, PCSrc, WbSel;
    logic [3:0]  State;

    logic        wd_reset;
    logic        wd_ready;
    logic        wd_pcwrite, wd_irwrite, wd_memreq, wd_memwe, wd_iord, wd_regwrite, wd_timeout;
    logic [1:0]  wd_alusrca, wd_alusrcb, wd_aluop, wd_pcsrc, wd_wbsel;
    logic [3:0]  wd_state;
`ifdef ILLEGAL_TRAP_EN
    logic        Illegal;
    logic        wd_illegal;
`endif

    int total = 0;
    int bad   = 0;

    // Field order of the control bundle:
    // PCWrite IRWrite MemReq MemWe IorD RegWrite ALUSrcA ALUSrcB ALUOp PCSrc WbSel Timeout
    logic [16:0] dut_sig;
    logic [16:0] wd_sig;
    assign dut_sig = {PCWrite, IRWrite, MemReq, MemWe, IorD, RegWrite,
                      ALUSrcA, ALUSrcB, ALUOp, PCSrc, WbSel, Timeout};
    assign wd_sig  = {wd_pcwrite, wd_irwrite, wd_memreq, wd_memwe, wd_iord, wd_regwrite,
                      wd_alusrca, wd_alusrcb, wd_aluop, wd_pcsrc, wd_wbsel, wd_timeout};

    localparam logic [16:0] S_IDLE   = 17'b0_0_0_0_0_0_00_00_00_00_00_0;
    localparam logic [16:0] S_FWAIT  = 17'b0_0_1_0_0_0_00_01_00_00_00_0;
    localparam logic [16:0] S_FDONE  = 17'b1_1_1_0_0_0_00_01_00_00_00_0;
    localparam logic [16:0] S_DEC    = 17'b0_0_0_0_0_0_01_10_00_00_00_0;
    localparam logic [16:0] S_XIMM   = 17'b0_0_0_0_0_0_10_10_10_00_00_0;
    localparam logic [16:0] S_XREG   = 17'b0_0_0_0_0_0_10_00_10_00_00_0;
    localparam logic [16:0] S_WBALU  = 17'b0_0_0_0_0_1_00_00_00_00_00_0;
    localparam logic [16:0] S_ADDR   = 17'b0_0_0_0_0_0_10_10_00_00_00_0;
    localparam logic [16:0] S_MRD    = 17'b0_0_1_0_1_0_00_00_00_00_00_0;
    localparam logic [16:0] S_MWR    = 17'b0_0_1_1_1_0_00_00_00_00_00_0;
    localparam logic [16:0] S_WBMEM  = 17'b0_0_0_0_0_1_00_00_00_00_01_0;
    localparam logic [16:0] S_BR_NT  = 17'b0_0_0_0_0_0_10_00_01_01_00_0;
    localparam logic [16:0] S_BR_T   = 17'b1_0_0_0_0_0_10_00_01_01_00_0;
    localparam logic [16:0] S_JAL    = 17'b1_0_0_0_0_1_00_00_00_01_10_0;
    localparam logic [16:0] S_JALR   = 17'b1_0_0_0_0_1_10_10_00_10_10_0;
    localparam logic [16:0] S_WDFIRE = 17'b0_0_0_0_0_0_00_01_00_00_00_1;

    multicycle_control_fsm u_dut (
        .Clk(Clk), .Reset(Reset), .Instr(Instr), .BranchTaken(BranchTaken), .MemReady(MemReady),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .MemReq(MemReq), .MemWe(MemWe), .IorD(IorD),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc),
        .WbSel(WbSel), .State(State), .Timeout(Timeout)
`ifdef ILLEGAL_TRAP_EN
        , .Illegal(Illegal)
`endif
    );

    multicycle_control_fsm #(.MEM_WAIT_MAX(4)) u_wd (
        .Clk(Clk), .Reset(wd_reset), .Instr(Instr), .BranchTaken(BranchTaken), .MemReady(wd_ready),
        .PCWrite(wd_pcwrite), .IRWrite(wd_irwrite), .MemReq(wd_memreq), .MemWe(wd_memwe), .IorD(wd_iord),
        .RegWrite(wd_regwrite), .ALUSrcA(wd_alusrca), .ALUSrcB(wd_alusrcb), .ALUOp(wd_aluop), .PCSrc(wd_pcsrc),
        .WbSel(wd_wbsel), .State(wd_state), .Timeout(wd_timeout)
`ifdef ILLEGAL_TRAP_EN
        , .Illegal(wd_illegal)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle of u_dut: drive the inputs at negedge, then check state and control bundle 1ns later.
    task automatic step(input string tag, input logic rdy, input logic tkn,
                        input logic [3:0] st, input logic [16:0] exp);
        @(negedge Clk);
        MemReady    = rdy;
        BranchTaken = tkn;
        #1;
        chk({tag, ".state"}, 32'(State), 32'(st));
        chk({tag, ".ctl"}, 32'(dut_sig), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        Reset = 1'b1; Instr = 32'h0; BranchTaken = 1'b0; MemReady = 1'b0;
        wd_reset = 1'b1; wd_ready = 1'b0;

        // Reset state; IRWrite/PCWrite must stay low even with MemReady high
        @(negedge Clk);
        MemReady = 1'b1;
        #1;
        chk("reset.state", 32'(State), 32'd0);
        chk("reset.ctl", 32'(dut_sig), 32'(S_IDLE));
        MemReady = 1'b0;
        Reset    = 1'b0;

        // Long fetch stall with watchdog disabled: no timeout, request held
        for (int i = 0; i < 6; i++) step("fstall", 1'b0, 1'b0, 4'd0, S_FWAIT);
        $display("txn fetch_stall 6 cycles");

        // addi x1,x0,5
        Instr = 32'h00500093;
        step("addi.f", 1'b1, 1'b0, 4'd0, S_FDONE);
        step("addi.d", 1'b1, 1'b0, 4'd1, S_DEC);
        step("addi.x", 1'b1, 1'b0, 4'd6, S_XIMM);
        step("addi.w", 1'b1, 1'b0, 4'd7, S_WBALU);
        $display("txn addi 4 cycles");

        // add x3,x1,x2 (R-type uses rs2)
        Instr = 32'h002081B3;
        step("add.f", 1'b1, 1'b0, 4'd0, S_FDONE);
        step("add.d", 1'b1, 1'b0, 4'd1, S_DEC);
        step("add.x", 1'b1, 1'b0, 4'd6, S_XREG);
        step("add.w", 1'b1, 1'b0, 4'd7, S_WBALU);
        $display("txn add 4 cycles");

        // lw x2,0(x1) with 3 stall cycles in MEM_RD
        Instr = 32'h0000A103;
        step("lw.f", 1'b1, 1'b0, 4'd0, S_FDONE);
        step("lw.d", 1'b1, 1'b0, 4'd1, S_DEC);
        step("lw.a", 1'b1, 1'b0, 4'd2, S_ADDR);
        for (int i = 0; i < 3; i++) step("lw.mwait", 1'b0, 1'b0, 4'd3, S_MRD);
        step("lw.m", 1'b1, 1'b0, 4'd3, S_MRD);
        step("lw.w", 1'b1, 1'b0, 4'd5, S_WBMEM);
        $display("txn lw 5 cycles + 3 wait");

        // sw x2,0(x1)
        Instr = 32'h0020A023;
        step("sw.f", 1'b1, 1'b0, 4'd0, S_FDONE);
        step("sw.d", 1'b1, 1'b0, 4'd1, S_DEC);
        step("sw.a", 1'b1, 1'b0, 4'd2, S_ADDR);
        step("sw.m", 1'b1, 1'b0, 4'd4, S_MWR);
        $display("txn sw 4 cycles");

        // beq not taken, then taken
        Instr = 32'h00208063;
        step("beq0.f", 1'b1, 1'b0, 4'd0, S_FDONE);
        step("beq0.d", 1'b1, 1'b0, 4'd1, S_DEC);
        step("beq0.b", 1'b1, 1'b0, 4'd8, S_BR_NT);
        $display("txn beq not-taken 3 cycles");
        step("beq1.f", 1'b1, 1'b1, 4'd0, S_FDONE);
        step("beq1.d", 1'b1, 1'b1, 4'd1, S_DEC);
        step("beq1.b", 1'b1, 1'b1, 4'd8, S_BR_T);
        $display("txn beq taken 3 cycles");

        // jal x0,0
        Instr = 32'h0000006F;
        step("jal.f", 1'b1, 1'b0, 4'd0, S_FDONE);
        step("jal.d", 1'b1, 1'b0, 4'd1, S_DEC);
        step("jal.j", 1'b1, 1'b0, 4'd9, S_JAL);
        $display("txn jal 3 cycles");

        // jalr x1,0(x1)
        Instr = 32'h000080E7;
        step("jalr.f", 1'b1, 1'b0, 4'd0, S_FDONE);
        step("jalr.d", 1'b1, 1'b0, 4'd1, S_DEC);
        step("jalr.j", 1'b1, 1'b0, 4'd9, S_JALR);
        $display("txn jalr 3 cycles");

        // sw interrupted by reset on the 2nd MEM_WR wait cycle
        Instr = 32'h0020A023;
        step("swrst.f", 1'b1, 1'b0, 4'd0, S_FDONE);
        step("swrst.d", 1'b1, 1'b0, 4'd1, S_DEC);
        step("swrst.a", 1'b1, 1'b0, 4'd2, S_ADDR);
        step("swrst.w1", 1'b0, 1'b0, 4'd4, S_MWR);
        @(negedge Clk);
        Reset = 1'b1; MemReady = 1'b0;
        #1;
        chk("swrst.rst.ctl", 32'(dut_sig), 32'(S_IDLE));
        @(negedge Clk);
        Reset = 1'b0; MemReady = 1'b0;
        #1;
        chk("swrst.after.state", 32'(State), 32'd0);
        chk("swrst.after.ctl", 32'(dut_sig), 32'(S_FWAIT));
        $display("txn sw aborted by reset");

        // Unknown opcode
        Instr = 32'h0000007F;
        step("unk.f", 1'b1, 1'b0, 4'd0, S_FDONE);
        step("unk.d", 1'b1, 1'b0, 4'd1, S_DEC);
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 2; i++) begin
            step("unk.trap", 1'b1, 1'b0, 4'd10, S_IDLE);
            chk("unk.illegal", 32'(Illegal), 32'd1);
        end
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0; MemReady = 1'b0;
        #1;
        chk("unk.exit.state", 32'(State), 32'd0);
        chk("unk.exit.illegal", 32'(Illegal), 32'd0);
        $display("txn unknown opcode trapped");
`else
        step("unk.next", 1'b1, 1'b0, 4'd0, S_FDONE);
        $display("txn unknown opcode 2 cycles");
`endif

        // Watchdog, MEM_WAIT_MAX=4: fires on wait cycles 4 and 8 while the state stays in FETCH
        @(negedge Clk);
        wd_reset = 1'b0; wd_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("wd.state", 32'(wd_state), 32'd0);
            chk("wd.ctl", 32'(wd_sig), 32'((i == 3 || i == 7) ? S_WDFIRE : S_FWAIT));
            @(negedge Clk);
        end
        wd_ready = 1'b1;
        #1;
        chk("wd.fetch.ctl", 32'(wd_sig), 32'(S_FDONE));
        $display("txn watchdog 2 timeouts");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
